// File: rtl/tpu_tile_ctrl.sv
// Tile sequencer for the systolic array: per tile it streams K read addresses, drains the
// array skew, then hands ARRAY_SIZE result rows to a rotating set of output banks.
module tpu_tile_ctrl #(
  parameter int ARRAY_SIZE     = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int NUM_OUT_BANKS  = 3,
  parameter int MAX_TILES      = 64,
  parameter int K_MAX          = 64
) (
  input  logic                                                 clk,
  input  logic                                                 srstn,
  input  logic                                                 tpu_start,
  input  logic [$clog2(MAX_TILES+1)-1:0]                       cfg_num_tiles,
  input  logic [$clog2(K_MAX+1)-1:0]                           cfg_k_depth,
  output logic [ADDR_WIDTH-1:0]                                sram_raddr,
  output logic                                                 sram_ren,
  output logic                                                 alu_start,
  output logic                                                 acc_clear,
  output logic [$clog2(K_MAX+2*ARRAY_SIZE)-1:0]                cycle_num,
  output logic [$clog2(MAX_TILES)-1:0]                         matrix_index,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [((NUM_OUT_BANKS > 1) ? $clog2(NUM_OUT_BANKS) : 1)-1:0] out_bank,
  output logic [OUT_ADDR_WIDTH-1:0]                            out_waddr,
  output logic [$clog2(ARRAY_SIZE)-1:0]                        out_row,
  output logic                                                 busy,
  output logic                                                 tpu_done,
  output logic [2:0]                                           state_dbg
);

  localparam int NW        = $clog2(MAX_TILES+1);
  localparam int KW        = $clog2(K_MAX+1);
  localparam int CW        = $clog2(K_MAX+2*ARRAY_SIZE);
  localparam int TW        = $clog2(MAX_TILES);
  localparam int BW        = (NUM_OUT_BANKS > 1) ? $clog2(NUM_OUT_BANKS) : 1;
  localparam int RW        = $clog2(ARRAY_SIZE);
  localparam int FLUSH_LEN = 2*ARRAY_SIZE - 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]             k_eff_q;
  logic [NW-1:0]             num_tiles_q;
  logic [TW-1:0]             tile_q;
  logic [CW-1:0]             cnt_q;
  logic [RW-1:0]             row_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [BW-1:0]             bank_q;
  logic [OUT_ADDR_WIDTH-1:0] row_base_q;
  logic                      alu_start_q;
  logic                      acc_clear_q;
  logic [CW-1:0]             cycle_num_q;

  logic start_acc, zero_run, load_last, flush_last, row_last, xfer, more_tiles, win;

  // cnt_q runs continuously across LOAD and FLUSH so it doubles as the compute-window index.
  assign start_acc  = ((state_q == S_IDLE) || (state_q == S_DONE)) && tpu_start;
  assign zero_run   = (num_tiles_q == '0);
  assign load_last  = (cnt_q == (CW'(k_eff_q) - CW'(1)));
  assign flush_last = (cnt_q == (CW'(k_eff_q) + CW'(FLUSH_LEN - 1)));
  assign row_last   = (row_q == RW'(ARRAY_SIZE - 1));
  assign xfer       = (state_q == S_WRITE) && out_ready;
  assign more_tiles = ((NW'(tile_q) + NW'(1)) < num_tiles_q);
  assign win        = ((state_q == S_LOAD) && !zero_run) || (state_q == S_FLUSH);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (tpu_start) state_d = S_LOAD;
      S_LOAD: begin
        if (zero_run)       state_d = S_DONE;
        else if (load_last) state_d = (FLUSH_LEN > 0) ? S_FLUSH : S_WRITE;
      end
      S_FLUSH: if (flush_last) state_d = S_WRITE;
      S_WRITE: if (xfer && row_last) state_d = more_tiles ? S_LOAD : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      k_eff_q     <= '0;
      num_tiles_q <= '0;
      tile_q      <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      bank_q      <= '0;
      row_base_q  <= '0;
    end else if (start_acc) begin
      k_eff_q     <= (cfg_k_depth == '0) ? KW'(1) : cfg_k_depth;
      num_tiles_q <= cfg_num_tiles;
      tile_q      <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      bank_q      <= '0;
      row_base_q  <= '0;
    end else begin
      unique case (state_q)
        S_LOAD, S_FLUSH: cnt_q <= cnt_q + CW'(1);
        S_WRITE: begin
          if (out_ready) begin
            if (row_last) begin
              row_q <= '0;
              cnt_q <= '0;
              if (more_tiles) begin
                tile_q <= tile_q + TW'(1);
                base_q <= base_q + ADDR_WIDTH'(k_eff_q);
                // Each full bank rotation advances the row region used in every bank.
                if (bank_q == BW'(NUM_OUT_BANKS - 1)) begin
                  bank_q     <= '0;
                  row_base_q <= row_base_q + OUT_ADDR_WIDTH'(ARRAY_SIZE);
                end else begin
                  bank_q <= bank_q + BW'(1);
                end
              end
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes lag LOAD/FLUSH by one cycle to line up with the SRAM read latency.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      alu_start_q <= 1'b0;
      acc_clear_q <= 1'b0;
      cycle_num_q <= '0;
    end else begin
      alu_start_q <= win;
      acc_clear_q <= (state_q == S_LOAD) && !zero_run && (cnt_q == '0);
      cycle_num_q <= win ? cnt_q : '0;
    end
  end

  // Write-out handshake: a row transfers on a cycle where out_valid and out_ready are both
  // high; while out_valid is high and out_ready low, out_row/out_bank/out_waddr stay fixed
  // and out_valid stays high until the transfer happens.
  always_comb begin
    sram_ren   = (state_q == S_LOAD) && !zero_run;
    sram_raddr = '0;
    if (sram_ren) sram_raddr = base_q + ADDR_WIDTH'(cnt_q);
    out_valid  = (state_q == S_WRITE);
    out_row    = '0;
    out_bank   = '0;
    out_waddr  = '0;
    if (out_valid) begin
      out_row   = row_q;
      out_bank  = bank_q;
      out_waddr = row_base_q + OUT_ADDR_WIDTH'(row_q);
    end
    busy         = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_WRITE);
    tpu_done     = (state_q == S_DONE);
    matrix_index = tile_q;
    alu_start    = alu_start_q;
    acc_clear    = acc_clear_q;
    cycle_num    = cycle_num_q;
    state_dbg    = state_q;
  end

  property p_write_hold;
    @(posedge clk) disable iff (!srstn)
      (out_valid && !out_ready) |=>
        (out_valid && $stable(out_row) && $stable(out_bank) && $stable(out_waddr));
  endproperty
  a_write_hold: assert property (p_write_hold);

  property p_done_not_busy;
    @(posedge clk) disable iff (!srstn) tpu_done |-> !busy;
  endproperty
  a_done_not_busy: assert property (p_done_not_busy);

  property p_ren_in_run;
    @(posedge clk) disable iff (!srstn) sram_ren |-> busy;
  endproperty
  a_ren_in_run: assert property (p_ren_in_run);

endmodule
